// File: rtl/traffic_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | traffic_pkg                                                                |
// | Lamp encodings and controller state codes shared by the light controller.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package traffic_pkg;

  localparam int         c_lamp_w       = 3;
  localparam logic [2:0] c_light_red    = 3'b001;
  localparam logic [2:0] c_light_yellow = 3'b010;
  localparam logic [2:0] c_light_green  = 3'b100;

  typedef enum logic [2:0] {
    ST_ALLRED = 3'd0,
    ST_GREEN  = 3'd1,
    ST_YELLOW = 3'd2,
    ST_PED    = 3'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/phase_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | phase_timer                                                                |
// | Loadable down-counter; holds at zero and flags it.                         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module phase_timer #(
  parameter int            TW      = 5,
  parameter logic [TW-1:0] RST_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  input  logic          en,
  output logic [TW-1:0] count,
  output logic          zero
);

  logic [TW-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= RST_VAL;
    end else if (load) begin
      r_count <= load_val;
    end else if (en && (r_count != '0)) begin
      r_count <= r_count - TW'(1);
    end
  end

  assign count = r_count;
  assign zero  = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/multi_phase_light_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | multi_phase_light_controller                                               |
// | N-phase intersection controller: round-robin greens, extension, all-walk.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module multi_phase_light_controller
  import traffic_pkg::*;
#(
  parameter int N_PHASES = 4,
  parameter int TW       = 5,
  parameter int T_GREEN  = 10,
  parameter int T_EXT    = 4,
  parameter int MAX_EXT  = 3,
  parameter int T_YELLOW = 5,
  parameter int T_ALLRED = 2,
  parameter int T_PED    = 15
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_PHASES-1:0]           car_req,
  input  logic                          ped_req,
  output logic [3*N_PHASES-1:0]         light,
  output logic [N_PHASES-1:0]           walk,
  output logic [$clog2(N_PHASES)-1:0]   active_phase,
  output logic [2:0]                    state_out
);

  localparam int PW    = $clog2(N_PHASES);
  localparam int EXT_W = (MAX_EXT > 0) ? $clog2(MAX_EXT + 1) : 1;
  localparam logic [EXT_W-1:0] c_max_ext = EXT_W'(MAX_EXT);

  state_t                  r_state, w_state_nx;
  logic [PW-1:0]           r_phase, w_phase_nx, w_sel;
  logic                    r_ped, w_ped_nx, w_enter_ped;
  logic [EXT_W-1:0]        r_ext, w_ext_nx;
  logic                    w_load, w_zero;
  logic [TW-1:0]           w_load_val, w_count;
  logic [N_PHASES-1:0]     w_onehot;
  logic [3*N_PHASES-1:0]   r_light, w_light_nx;
  logic [N_PHASES-1:0]     r_walk, w_walk_nx;

  phase_timer #(
    .TW      (TW),
    .RST_VAL (TW'(T_ALLRED - 1))
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (w_load),
    .load_val (w_load_val),
    .en       (1'b1),
    .count    (w_count),
    .zero     (w_zero)
  );

  // Scan from the farthest offset down so the nearest requesting phase wins.
  always_comb begin
    w_sel = PW'((int'(r_phase) + 1) % N_PHASES);
    for (int i = N_PHASES; i >= 1; i--) begin
      if (car_req[PW'((int'(r_phase) + i) % N_PHASES)]) begin
        w_sel = PW'((int'(r_phase) + i) % N_PHASES);
      end
    end
  end

  assign w_onehot = N_PHASES'(1) << r_phase;

  always_comb begin
    w_state_nx  = r_state;
    w_phase_nx  = r_phase;
    w_ext_nx    = r_ext;
    w_load      = 1'b0;
    w_load_val  = w_count;
    w_enter_ped = 1'b0;
    case (r_state)
      ST_ALLRED: begin
        if (w_zero) begin
          w_load = 1'b1;
          if (r_ped) begin
            w_state_nx  = ST_PED;
            w_load_val  = TW'(T_PED - 1);
            w_enter_ped = 1'b1;
          end else begin
            w_state_nx = ST_GREEN;
            w_phase_nx = w_sel;
            w_ext_nx   = '0;
            w_load_val = TW'(T_GREEN - 1);
          end
        end
      end
      ST_GREEN: begin
        if (w_zero) begin
          w_load = 1'b1;
          if (!r_ped && (car_req == w_onehot) && (r_ext < c_max_ext)) begin
            w_load_val = TW'(T_EXT - 1);
            w_ext_nx   = r_ext + EXT_W'(1);
          end else begin
            w_state_nx = ST_YELLOW;
            w_load_val = TW'(T_YELLOW - 1);
          end
        end
      end
      ST_YELLOW, ST_PED: begin
        if (w_zero) begin
          w_load     = 1'b1;
          w_state_nx = ST_ALLRED;
          w_load_val = TW'(T_ALLRED - 1);
        end
      end
      default: begin
        w_load     = 1'b1;
        w_state_nx = ST_ALLRED;
        w_load_val = TW'(T_ALLRED - 1);
      end
    endcase
  end

  // A press made during the walk interval itself is deliberately dropped.
  assign w_ped_nx = w_enter_ped ? 1'b0 : (r_ped | (ped_req && (r_state != ST_PED)));

  for (genvar g = 0; g < N_PHASES; g++) begin : g_lamp
    assign w_light_nx[c_lamp_w*g +: c_lamp_w] =
      ((w_state_nx == ST_GREEN)  && (w_phase_nx == PW'(g))) ? c_light_green  :
      ((w_state_nx == ST_YELLOW) && (w_phase_nx == PW'(g))) ? c_light_yellow :
                                                              c_light_red;
    assign w_walk_nx[g] = (w_state_nx == ST_PED) ||
                          ((w_state_nx == ST_GREEN) && (w_phase_nx == PW'(g)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_ALLRED;
      r_phase <= PW'(N_PHASES - 1);
      r_ped   <= 1'b0;
      r_ext   <= '0;
      r_light <= {N_PHASES{c_light_red}};
      r_walk  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_phase <= w_phase_nx;
      r_ped   <= w_ped_nx;
      r_ext   <= w_ext_nx;
      r_light <= w_light_nx;
      r_walk  <= w_walk_nx;
    end
  end

  assign light        = r_light;
  assign walk         = r_walk;
  assign active_phase = r_phase;
  assign state_out    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multi_phase_light_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_multi_phase_light_controller                                            |
// | Interval-level reference model, vector table and corner-case sequences.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_multi_phase_light_controller;

  localparam int N        = 4;
  localparam int T_GREEN  = 10;
  localparam int T_EXT    = 4;
  localparam int MAX_EXT  = 3;
  localparam int T_YELLOW = 5;
  localparam int T_ALLRED = 2;
  localparam int T_PED    = 15;

  localparam int K_AR = 0, K_G = 1, K_Y = 2, K_P = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   car_req = '0;
  logic           ped_req = 1'b0;
  logic [3*N-1:0] light;
  logic [N-1:0]   walk;
  logic [1:0]     active_phase;
  logic [2:0]     state_out;

  int errors = 0;
  int checks = 0;

  multi_phase_light_controller #(
    .N_PHASES (N), .TW (5), .T_GREEN (T_GREEN), .T_EXT (T_EXT), .MAX_EXT (MAX_EXT),
    .T_YELLOW (T_YELLOW), .T_ALLRED (T_ALLRED), .T_PED (T_PED)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .car_req      (car_req),
    .ped_req      (ped_req),
    .light        (light),
    .walk         (walk),
    .active_phase (active_phase),
    .state_out    (state_out)
  );

  always #5 clk = ~clk;

  // Reference model: current interval kind, cycles left in it, granted phase.
  int m_kind, m_left, m_phase, m_ext;
  bit m_ped;

  task automatic model_reset();
    m_kind = K_AR; m_left = T_ALLRED; m_phase = N - 1; m_ped = 0; m_ext = 0;
  endtask

  function automatic int pick(input logic [N-1:0] car, input int from);
    for (int i = 1; i <= N; i++)
      if (car[(from + i) % N]) return (from + i) % N;
    return (from + 1) % N;
  endfunction

  task automatic model_step(input logic [N-1:0] car, input logic ped);
    bit old_ped  = m_ped;
    int old_kind = m_kind;
    bit into_ped = 0;
    m_left = m_left - 1;
    if (m_left == 0) begin
      case (m_kind)
        K_AR: if (old_ped) begin
                m_kind = K_P; m_left = T_PED; into_ped = 1;
              end else begin
                m_phase = pick(car, m_phase); m_kind = K_G; m_left = T_GREEN; m_ext = 0;
              end
        K_G:  if (!old_ped && car == N'(1 << m_phase) && m_ext < MAX_EXT) begin
                m_left = T_EXT; m_ext++;
              end else begin
                m_kind = K_Y; m_left = T_YELLOW;
              end
        default: begin m_kind = K_AR; m_left = T_ALLRED; end
      endcase
    end
    m_ped = into_ped ? 1'b0 : (old_ped | (ped && old_kind != K_P));
  endtask

  function automatic logic [3*N-1:0] exp_light();
    logic [3*N-1:0] l;
    for (int k = 0; k < N; k++) begin
      l[3*k +: 3] = 3'b001;
      if (k == m_phase && m_kind == K_G) l[3*k +: 3] = 3'b100;
      if (k == m_phase && m_kind == K_Y) l[3*k +: 3] = 3'b010;
    end
    return l;
  endfunction

  function automatic logic [N-1:0] exp_walk();
    if (m_kind == K_P) return '1;
    if (m_kind == K_G) return N'(1 << m_phase);
    return '0;
  endfunction

  // Classify what the lamps show: AR, green, yellow, walk interval, or -1.
  function automatic int obs_kind();
    int g = 0, y = 0, r = 0;
    for (int k = 0; k < N; k++) begin
      if (light[3*k +: 3] == 3'b100) g++;
      else if (light[3*k +: 3] == 3'b010) y++;
      else if (light[3*k +: 3] == 3'b001) r++;
    end
    if (r == N && walk == '0) return K_AR;
    if (r == N && walk == '1) return K_P;
    if (g == 1 && r == N - 1) return K_G;
    if (y == 1 && r == N - 1) return K_Y;
    return -1;
  endfunction

  function automatic int green_of();
    for (int k = 0; k < N; k++) if (light[3*k +: 3] == 3'b100) return k;
    return -1;
  endfunction

  task automatic check_val(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic check_model(input string name);
    checks++;
    if (light !== exp_light() || walk !== exp_walk() || active_phase !== 2'(m_phase)) begin
      errors++;
      $display("FAIL %s @%0t: got light=%h walk=%b phase=%0d expected light=%h walk=%b phase=%0d",
               name, $time, light, walk, active_phase, exp_light(), exp_walk(), m_phase);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(car_req, ped_req);
    @(negedge clk);
    check_model("model");
  endtask

  task automatic do_reset();
    car_req = '0; ped_req = 1'b0; rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_model("reset");
  endtask

  // Counts consecutive cycles showing interval kind k; optional press on the 5th.
  task automatic count_kind(input int k, input bit press5, output int n);
    n = 0;
    while (obs_kind() == k && n < 100) begin
      n++;
      ped_req = (press5 && n == 5);
      tick();
      ped_req = 1'b0;
    end
  endtask

  task automatic measure_green(output int ph, output int len);
    int guard = 0;
    len = 0;
    while (green_of() < 0 && guard < 200) begin tick(); guard++; end
    ph = green_of();
    if (ph < 0) begin
      check_val("green_timeout", guard, 0);
      return;
    end
    while (green_of() == ph && len < 200) begin len++; tick(); end
  endtask

  typedef struct {
    logic [N-1:0] car;
    int p0, p1, p2, p3;
    int glen;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int ph, len, n, guard;

    tbl[0] = '{car: 4'b0000, p0: 0, p1: 1, p2: 2, p3: 3, glen: 10};
    tbl[1] = '{car: 4'b1010, p0: 1, p1: 3, p2: 1, p3: 3, glen: 10};
    tbl[2] = '{car: 4'b0001, p0: 0, p1: 0, p2: 0, p3: 0, glen: 22};
    tbl[3] = '{car: 4'b0100, p0: 2, p1: 2, p2: 2, p3: 2, glen: 22};
    tbl[4] = '{car: 4'b1001, p0: 0, p1: 3, p2: 0, p3: 3, glen: 10};
    tbl[5] = '{car: 4'b1111, p0: 0, p1: 1, p2: 2, p3: 3, glen: 10};

    // Reset values and first interval timings
    do_reset();
    check_val("rst_light", int'(light), int'({N{3'b001}}));
    check_val("rst_walk", int'(walk), 0);
    check_val("rst_phase", int'(active_phase), N - 1);
    count_kind(K_AR, 1'b0, n);  check_val("first_allred", n, T_ALLRED);
    check_val("first_green_phase", green_of(), 0);
    count_kind(K_G, 1'b0, n);   check_val("green_len", n, T_GREEN);
    count_kind(K_Y, 1'b0, n);   check_val("yellow_len", n, T_YELLOW);
    count_kind(K_AR, 1'b0, n);  check_val("allred_len", n, T_ALLRED);
    check_val("second_green_phase", green_of(), 1);

    for (int v = 0; v < 6; v++) begin
      do_reset();
      car_req = tbl[v].car;
      measure_green(ph, len); check_val("tbl_ph0", ph, tbl[v].p0); check_val("tbl_len", len, tbl[v].glen);
      measure_green(ph, len); check_val("tbl_ph1", ph, tbl[v].p1); check_val("tbl_len", len, tbl[v].glen);
      measure_green(ph, len); check_val("tbl_ph2", ph, tbl[v].p2); check_val("tbl_len", len, tbl[v].glen);
      measure_green(ph, len); check_val("tbl_ph3", ph, tbl[v].p3); check_val("tbl_len", len, tbl[v].glen);
    end

    // Pedestrian pulse during phase 2 green, second press during the walk
    do_reset();
    guard = 0;
    while (green_of() != 2 && guard < 200) begin tick(); guard++; end
    check_val("reach_phase2", green_of(), 2);
    len = 1;
    ped_req = 1'b1; tick(); ped_req = 1'b0;
    while (green_of() == 2 && len < 100) begin len++; tick(); end
    check_val("ped_green_len", len, T_GREEN);
    count_kind(K_Y, 1'b0, n);   check_val("ped_yellow", n, T_YELLOW);
    count_kind(K_AR, 1'b0, n);  check_val("ped_allred1", n, T_ALLRED);
    count_kind(K_P, 1'b1, n);   check_val("ped_walk_len", n, T_PED);
    count_kind(K_AR, 1'b0, n);  check_val("ped_allred2", n, T_ALLRED);
    check_val("after_ped_phase", green_of(), 3);

    // Async reset in the middle of yellow
    do_reset();
    guard = 0;
    while (obs_kind() != K_Y && guard < 200) begin tick(); guard++; end
    tick();
    #2 rst = 1'b1;
    #1;
    check_val("midrst_light", int'(light), int'({N{3'b001}}));
    check_val("midrst_walk", int'(walk), 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_model("midrst_release");
    count_kind(K_AR, 1'b0, n);  check_val("midrst_allred", n, T_ALLRED);
    check_val("midrst_green", green_of(), 0);

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 19) == 0) begin
        case ($urandom_range(0, 2))
          0: car_req = N'($urandom_range(0, 15));
          1: car_req = N'(1 << $urandom_range(0, N - 1));
          default: car_req = '0;
        endcase
      end
      ped_req = ($urandom_range(0, 60) == 0);
      tick();
    end
    ped_req = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
